// File: rtl/loot_reel_scorer.sv
// Loot reel scorer: tracks a claw catching gold/rock loot, reels it in over a
// number of video frames, then awards level-scaled points with 16-bit saturation.
module loot_reel_scorer #(
    parameter int GOLD_VALUE       = 50,
    parameter int ROCK_VALUE       = 10,
    parameter int GOLD_REEL_FRAMES = 30,
    parameter int ROCK_REEL_FRAMES = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start_level,
    input  logic [2:0]  level_num,
    input  logic [7:0]  total_amount,
    input  logic [2:0]  caught_loot_type,
    input  logic        start_of_frame,
    output logic [2:0]  loot_in_hand,
    output logic        reel_busy,
    output logic [15:0] score,
    output logic        score_pulse,
    output logic [7:0]  collected_count,
    output logic        level_done
);

    typedef enum logic [2:0] {
        IDLE_ST,
        ARM_ST,
        WAIT_CATCH_ST,
        REEL_ST,
        AWARD_ST,
        DONE_ST
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_target;
    logic [7:0]  r_reel_cnt;
    logic [2:0]  r_loot;
    logic        r_busy;
    logic [15:0] r_score;
    logic        r_pulse;
    logic [7:0]  r_count;
    logic        r_done;

    logic        w_catch_valid;
    logic        w_last_frame;
    logic [16:0] w_value;

    // Gold is worth more on later levels; level 0 behaves like level 1.
    function automatic logic [16:0] award_value(input logic [2:0] ltype, input logic [2:0] lvl);
        logic [2:0] sh;
        sh = (lvl <= 3'd1) ? 3'd0 : lvl - 3'd1;
        if (ltype == 3'd1)
            award_value = 17'(GOLD_VALUE) << sh;
        else
            award_value = 17'(ROCK_VALUE);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] v);
        logic [17:0] s;
        s = {2'b00, a} + {1'b0, v};
        sat_add = (s > 18'h0FFFF) ? 16'hFFFF : s[15:0];
    endfunction

    assign w_catch_valid = (caught_loot_type == 3'd1) || (caught_loot_type == 3'd2);
    assign w_last_frame  = start_of_frame && (r_reel_cnt == 8'd1);
    assign w_value       = award_value(r_loot, level_num);

    always_ff @(posedge clk) begin
        if (resetN)
            r_state <= IDLE_ST;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE_ST:       w_next_state = IDLE_ST;
            ARM_ST:        w_next_state = (total_amount == 8'd0) ? DONE_ST : WAIT_CATCH_ST;
            WAIT_CATCH_ST: if (w_catch_valid) w_next_state = REEL_ST;
            REEL_ST:       if (w_last_frame) w_next_state = AWARD_ST;
            AWARD_ST:      w_next_state = (r_count >= r_target) ? DONE_ST : WAIT_CATCH_ST;
            DONE_ST:       w_next_state = DONE_ST;
            default:       w_next_state = IDLE_ST;
        endcase
        if (start_level)
            w_next_state = ARM_ST;
    end

    // Score is applied on the final frame edge so score_pulse is visible during AWARD_ST.
    always_ff @(posedge clk) begin
        if (resetN) begin
            r_target   <= 8'd0;
            r_reel_cnt <= 8'd0;
            r_loot     <= 3'd0;
            r_busy     <= 1'b0;
            r_score    <= 16'd0;
            r_pulse    <= 1'b0;
            r_count    <= 8'd0;
            r_done     <= 1'b0;
        end else if (start_level) begin
            r_reel_cnt <= 8'd0;
            r_loot     <= 3'd0;
            r_busy     <= 1'b0;
            r_pulse    <= 1'b0;
            r_count    <= 8'd0;
            r_done     <= 1'b0;
            if (level_num <= 3'd1)
                r_score <= 16'd0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                ARM_ST: begin
                    r_target <= total_amount;
                    r_done   <= (total_amount == 8'd0);
                end
                WAIT_CATCH_ST: begin
                    if (w_catch_valid) begin
                        r_loot     <= caught_loot_type;
                        r_busy     <= 1'b1;
                        r_reel_cnt <= (caught_loot_type == 3'd1) ? 8'(GOLD_REEL_FRAMES)
                                                                 : 8'(ROCK_REEL_FRAMES);
                    end
                end
                REEL_ST: begin
                    if (start_of_frame && (r_reel_cnt != 8'd0))
                        r_reel_cnt <= r_reel_cnt - 8'd1;
                    if (w_last_frame) begin
                        r_score <= sat_add(r_score, w_value);
                        r_pulse <= 1'b1;
                        r_count <= (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                        r_loot  <= 3'd0;
                        r_busy  <= 1'b0;
                    end
                end
                AWARD_ST: begin
                    r_done <= (r_count >= r_target);
                end
                default: ;
            endcase
        end
    end

    assign loot_in_hand    = r_loot;
    assign reel_busy       = r_busy;
    assign score           = r_score;
    assign score_pulse     = r_pulse;
    assign collected_count = r_count;
    assign level_done      = r_done;

endmodule

// File: tb/tb_loot_reel_scorer.sv
// Testbench for loot_reel_scorer: directed level scenarios plus randomized
// levels, checked against a transaction-level scoring model.
module tb_loot_reel_scorer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start_level;
    logic [2:0]  level_num;
    logic [7:0]  total_amount;
    logic [2:0]  caught_loot_type;
    logic        start_of_frame;
    logic [2:0]  loot_in_hand;
    logic        reel_busy;
    logic [15:0] score;
    logic        score_pulse;
    logic [7:0]  collected_count;
    logic        level_done;

    int checks = 0;
    int errors = 0;

    int exp_score;
    int exp_count;
    int exp_target;
    int exp_lvl;

    always #5 clk = ~clk;

    loot_reel_scorer dut (
        .clk              (clk),
        .resetN           (resetN),
        .start_level      (start_level),
        .level_num        (level_num),
        .total_amount     (total_amount),
        .caught_loot_type (caught_loot_type),
        .start_of_frame   (start_of_frame),
        .loot_in_hand     (loot_in_hand),
        .reel_busy        (reel_busy),
        .score            (score),
        .score_pulse      (score_pulse),
        .collected_count  (collected_count),
        .level_done       (level_done)
    );

    function automatic int loot_value(input int t, input int lvl);
        int mult;
        mult = (lvl <= 1) ? 1 : (2 ** (lvl - 1));
        return (t == 1) ? 50 * mult : 10;
    endfunction

    function automatic int sat16(input int s);
        return (s > 65535) ? 65535 : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input int loot, input int busy, input int pulse, input int done);
        chk({tag, ".score"}, 32'(score), 32'(exp_score));
        chk({tag, ".count"}, 32'(collected_count), 32'(exp_count));
        chk({tag, ".loot"},  32'(loot_in_hand), 32'(loot));
        chk({tag, ".busy"},  32'(reel_busy), 32'(busy));
        chk({tag, ".pulse"}, 32'(score_pulse), 32'(pulse));
        chk({tag, ".done"},  32'(level_done), 32'(done));
    endtask

    task automatic do_reset();
        resetN = 1'b1;
        tick();
        resetN = 1'b0;
        exp_score = 0;
        exp_count = 0;
        exp_target = 0;
        check_all("reset", 0, 0, 0, 0);
    endtask

    task automatic start_lvl(input int lvl, input int amt);
        level_num    = 3'(lvl);
        total_amount = 8'(amt);
        start_level  = 1'b1;
        tick();
        start_level = 1'b0;
        if (lvl <= 1) exp_score = 0;
        exp_count  = 0;
        exp_target = amt;
        exp_lvl    = lvl;
        check_all("start", 0, 0, 0, 0);
        tick();
        total_amount = 8'($urandom_range(0, 255));
        check_all("arm", 0, 0, 0, (amt == 0) ? 1 : 0);
    endtask

    task automatic catch_loot(input int t);
        caught_loot_type = 3'(t);
        tick();
        caught_loot_type = 3'd0;
        check_all("catch", t, 1, 0, 0);
    endtask

    task automatic reel(input int t, input int inj);
        int frames;
        frames = (t == 1) ? 30 : 60;
        for (int f = 1; f <= frames; f++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (inj != 0 && f == frames / 2) begin
                caught_loot_type = 3'(inj);
                tick();
                caught_loot_type = 3'd0;
                chk("reel.ign_loot", 32'(loot_in_hand), 32'(t));
            end
            start_of_frame = 1'b1;
            tick();
            start_of_frame = 1'b0;
            if (f < frames) chk("reel.busy", 32'(reel_busy), 32'd1);
        end
        exp_score = sat16(exp_score + loot_value(t, exp_lvl));
        exp_count = (exp_count < 255) ? exp_count + 1 : 255;
        check_all("award", 0, 0, 1, 0);
        tick();
        check_all("post", 0, 0, 0, (exp_count >= exp_target) ? 1 : 0);
    endtask

    initial begin
        resetN           = 1'b1;
        start_level      = 1'b0;
        level_num        = 3'd1;
        total_amount     = 8'd0;
        caught_loot_type = 3'd0;
        start_of_frame   = 1'b0;
        exp_lvl          = 1;
        repeat (2) tick();
        do_reset();

        // gold on level 1, then a second gold completes the level at 100
        start_lvl(1, 2);
        caught_loot_type = 3'd5;
        tick();
        caught_loot_type = 3'd0;
        check_all("wait_ign5", 0, 0, 0, 0);
        catch_loot(1);
        reel(1, 2);
        catch_loot(1);
        reel(1, 0);
        chk("lvl1.score100", 32'(score), 32'd100);

        caught_loot_type = 3'd1;
        tick();
        caught_loot_type = 3'd0;
        check_all("done_ign", 0, 0, 0, 1);

        // level 3 with carried score: rock then gold
        start_lvl(3, 2);
        catch_loot(2);
        reel(2, 0);
        catch_loot(1);
        reel(1, 0);
        chk("lvl3.score310", 32'(score), 32'd310);

        // empty level
        start_lvl(4, 0);
        tick();
        check_all("empty_hold", 0, 0, 0, 1);

        // preemption mid-reel with simultaneous catch, level 1 clears score
        start_lvl(2, 3);
        catch_loot(1);
        repeat (5) begin
            start_of_frame = 1'b1;
            tick();
            start_of_frame = 1'b0;
        end
        level_num        = 3'd1;
        total_amount     = 8'd0;
        start_level      = 1'b1;
        caught_loot_type = 3'd1;
        tick();
        start_level      = 1'b0;
        caught_loot_type = 3'd0;
        exp_score = 0;
        exp_count = 0;
        check_all("preempt", 0, 0, 0, 0);
        tick();
        check_all("preempt_arm", 0, 0, 0, 1);

        // reset mid-reel discards loot, then idle ignores catches
        start_lvl(2, 2);
        catch_loot(2);
        repeat (10) begin
            start_of_frame = 1'b1;
            tick();
            start_of_frame = 1'b0;
        end
        do_reset();
        caught_loot_type = 3'd1;
        start_of_frame   = 1'b1;
        tick();
        caught_loot_type = 3'd0;
        start_of_frame   = 1'b0;
        check_all("idle_ign", 0, 0, 0, 0);

        // saturation: level 7 gold is worth 3200
        start_lvl(7, 21);
        for (int k = 0; k < 21; k++) begin
            catch_loot(1);
            reel(1, 0);
        end
        chk("sat.score", 32'(score), 32'hFFFF);
        check_all("sat.final", 0, 0, 0, 1);

        // randomized levels
        do_reset();
        repeat (6) begin
            int lvl;
            int amt;
            lvl = $urandom_range(0, 7);
            amt = $urandom_range(1, 3);
            start_lvl(lvl, amt);
            for (int k = 0; k < amt; k++) begin
                int t;
                if ($urandom_range(0, 1) == 1) begin
                    caught_loot_type = 3'($urandom_range(3, 7));
                    tick();
                    caught_loot_type = 3'd0;
                    chk("rnd.wait_ign", 32'(loot_in_hand), 32'd0);
                end
                repeat ($urandom_range(0, 3)) tick();
                t = $urandom_range(1, 2);
                catch_loot(t);
                reel(t, (k == 0) ? $urandom_range(1, 2) : 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
